// File: rtl/tile_row_coverage_pkg.sv
// pvr_raster_pkg: scanner state encoding, default widths and edge constant helper
package pvr_raster_pkg;
   typedef enum logic [1:0] {IDLE, SETUP, SCAN} state_t;
   localparam int EDGE_W_DEF = 48;
   localparam int FRAC_BITS_DEF = 4;
   function automatic logic signed [63:0] edge_c(input logic signed [63:0] fdx, fdy, fx, fy, input int frac);
      return ((fdy * fx) >>> frac) - ((fdx * fy) >>> frac);
   endfunction
endpackage

// File: rtl/tile_row_coverage_lane_priority_enc.sv
// lane_priority_enc: lowest and highest set lane of a coverage mask
module lane_priority_enc #(
   parameter int LANES = 32,
   localparam int LW = LANES > 1 ? $clog2(LANES) : 1
) (
   input  logic [LANES-1:0] mask,
   output logic [LW-1:0]    first,
   output logic [LW-1:0]    last,
   output logic             any
);
   always_comb begin
      first = '0;
      last = '0;
      for (int i = LANES - 1; i >= 0; i--) if (mask[i]) first = LW'(i);
      for (int i = 0; i < LANES; i++) if (mask[i]) last = LW'(i);
   end
   assign any = |mask;
endmodule

// File: rtl/tile_row_coverage.sv
// tile_row_coverage: incremental edge-function tile scanner emitting LANES-wide coverage chunks
module tile_row_coverage
   import pvr_raster_pkg::*;
#(
   parameter int LANES = 32,
   parameter int TILE_W = 32,
   parameter int TILE_H = 32,
   parameter int FRAC_BITS = FRAC_BITS_DEF,
   parameter int EDGE_W = EDGE_W_DEF,
   parameter bit SKIP_EMPTY = 1'b0,
   localparam int LW = LANES > 1 ? $clog2(LANES) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     setup_valid,
   output logic                     setup_ready,
   input  logic signed [31:0]       FX1,
   input  logic signed [31:0]       FX2,
   input  logic signed [31:0]       FX3,
   input  logic signed [31:0]       FX4,
   input  logic signed [31:0]       FY1,
   input  logic signed [31:0]       FY2,
   input  logic signed [31:0]       FY3,
   input  logic signed [31:0]       FY4,
   input  logic signed [EDGE_W-1:0] FDX12,
   input  logic signed [EDGE_W-1:0] FDY12,
   input  logic signed [EDGE_W-1:0] FDX23,
   input  logic signed [EDGE_W-1:0] FDY23,
   input  logic signed [EDGE_W-1:0] FDX31,
   input  logic signed [EDGE_W-1:0] FDY31,
   input  logic signed [EDGE_W-1:0] FDX41,
   input  logic signed [EDGE_W-1:0] FDY41,
   input  logic                     quad,
   input  logic [10:0]              tile_x0,
   input  logic [10:0]              tile_y0,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [LANES-1:0]         out_mask,
   output logic [10:0]              out_x,
   output logic [10:0]              out_y,
   output logic [LW-1:0]            out_first,
   output logic [LW-1:0]            out_last,
   output logic                     out_any,
   output logic                     out_row_last,
   output logic                     out_tile_last,
   output logic                     busy,
   output logic                     done
);
   localparam int CHUNKS = TILE_W / LANES;
   localparam int CXW = CHUNKS > 1 ? $clog2(CHUNKS) : 1;
   localparam int CYW = TILE_H > 1 ? $clog2(TILE_H) : 1;
   if (TILE_W % LANES != 0) begin : g_lanes_chk
      $error("TILE_W must be a multiple of LANES");
   end
   state_t state, state_n;
   logic signed [EDGE_W-1:0] fdx_r [4], fdy_r [4], acc [4], racc [4], acc_n [4], racc_n [4], c_e [4], lv;
   logic signed [31:0] fx_r [4], fy_r [4];
   logic quad_r, adv, fin, row_last, tile_last;
   logic [10:0] x0_r, y0_r;
   logic [CXW-1:0] cx;
   logic [CYW-1:0] cy;
   logic [LANES-1:0] mask_n;
   assign setup_ready = state == IDLE;
   assign busy = state != IDLE;
   assign row_last = cx == CXW'(CHUNKS - 1);
   assign tile_last = row_last && cy == CYW'(TILE_H - 1);
   // a skipped empty chunk advances without waiting for out_ready
   assign out_valid = state == SCAN && (!SKIP_EMPTY || out_any || tile_last);
   assign adv = state == SCAN && (out_valid ? out_ready : 1'b1);
   assign fin = adv && tile_last;
   assign out_row_last = out_valid && row_last;
   assign out_tile_last = out_valid && tile_last;
   assign out_x = x0_r + 11'(cx) * 11'(LANES);
   assign out_y = y0_r + 11'(cy);
   always_comb begin
      state_n = state;
      mask_n = '0;
      lv = '0;
      if (state == IDLE && setup_valid) state_n = SETUP;
      if (state == SETUP) state_n = SCAN;
      if (adv) state_n = tile_last ? IDLE : SCAN;
      for (int e = 0; e < 4; e++) begin
         c_e[e] = EDGE_W'(edge_c(64'(fdx_r[e]), 64'(fdy_r[e]), 64'(fx_r[e]), 64'(fy_r[e]), FRAC_BITS));
         racc_n[e] = state == SETUP ? c_e[e] + fdx_r[e] * EDGE_W'(y0_r) - fdy_r[e] * EDGE_W'(x0_r) :
                     adv && row_last ? racc[e] + fdx_r[e] : racc[e];
         acc_n[e] = state == SETUP || (adv && row_last) ? racc_n[e] :
                    adv ? acc[e] - EDGE_W'(LANES) * fdy_r[e] : acc[e];
      end
      // mask is evaluated on the next accumulator so the output register holds it directly
      for (int k = 0; k < LANES; k++) begin
         mask_n[k] = 1'b1;
         for (int e = 0; e < 4; e++) begin
            lv = acc_n[e] - EDGE_W'(k) * fdy_r[e];
            mask_n[k] = mask_n[k] & (!lv[EDGE_W-1] || (e == 3 && !quad_r));
         end
      end
   end
   always_ff @(posedge clk) begin
      if (setup_valid && setup_ready) begin
         fdx_r <= '{FDX12, FDX23, FDX31, FDX41};
         fdy_r <= '{FDY12, FDY23, FDY31, FDY41};
         fx_r <= '{FX1, FX2, FX3, FX4};
         fy_r <= '{FY1, FY2, FY3, FY4};
         quad_r <= quad;
      end
      acc <= acc_n;
      racc <= racc_n;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         done <= 1'b0;
         out_mask <= '0;
         cx <= '0;
         cy <= '0;
         x0_r <= '0;
         y0_r <= '0;
      end else begin
         state <= state_n;
         done <= fin;
         if (setup_valid && setup_ready) begin
            x0_r <= tile_x0;
            y0_r <= tile_y0;
         end
         if (state == SETUP || adv) begin
            out_mask <= fin ? '0 : mask_n;
            cx <= (fin || state == SETUP || row_last) ? '0 : cx + CXW'(1);
            cy <= (fin || state == SETUP) ? '0 : cy + CYW'(row_last);
         end
      end
   end
   lane_priority_enc #(.LANES(LANES)) u_enc (
      .mask(out_mask),
      .first(out_first),
      .last(out_last),
      .any(out_any)
   );
endmodule

// File: tb/tb_tile_row_coverage.sv
// tb_tile_row_coverage: table-driven scoreboard bench for the 32-lane scanner plus an 8-lane skipping instance
module tb_tile_row_coverage;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst, sv_a, sr_a, ov_a, or_a, any_a, rl_a, tl_a, busy_a, done_a;
   logic sv_b, sr_b, ov_b, any_b, rl_b, tl_b, busy_b, done_b, quad;
   logic signed [31:0] fx [4], fy [4];
   logic signed [47:0] fdx [4], fdy [4];
   logic [10:0] tx, ty, ox_a, oy_a, ox_b, oy_b, cur_ty;
   logic [31:0] om_a;
   logic [4:0] of_a, ol_a;
   logic [7:0] om_b;
   logic [2:0] of_b, ol_b;
   typedef struct packed {
      logic [10:0] x, y;
      logic [31:0] mask;
      logic [4:0] first, last;
      logic any, rl, tl;
   } chunk_t;
   typedef struct {
      logic quad_v;
      logic [10:0] tx, ty;
      bit bp;
      logic [31:0] row0, row31;
   } vec_t;
   chunk_t q[$];
   chunk_t cur, held, expc;
   vec_t vecs[5];
   logic [31:0] got_row [32];
   int n_chk = 0, n_err = 0, acc_cnt = 0, ph = 0;
   bit bp = 0, exp_done = 0, stalled = 0;
   tile_row_coverage dut_a (
      .clk(clk), .rst(rst), .setup_valid(sv_a), .setup_ready(sr_a),
      .FX1(fx[0]), .FX2(fx[1]), .FX3(fx[2]), .FX4(fx[3]),
      .FY1(fy[0]), .FY2(fy[1]), .FY3(fy[2]), .FY4(fy[3]),
      .FDX12(fdx[0]), .FDY12(fdy[0]), .FDX23(fdx[1]), .FDY23(fdy[1]),
      .FDX31(fdx[2]), .FDY31(fdy[2]), .FDX41(fdx[3]), .FDY41(fdy[3]),
      .quad(quad), .tile_x0(tx), .tile_y0(ty),
      .out_valid(ov_a), .out_ready(or_a), .out_mask(om_a), .out_x(ox_a), .out_y(oy_a),
      .out_first(of_a), .out_last(ol_a), .out_any(any_a), .out_row_last(rl_a),
      .out_tile_last(tl_a), .busy(busy_a), .done(done_a)
   );
   tile_row_coverage #(.LANES(8), .SKIP_EMPTY(1'b1)) dut_b (
      .clk(clk), .rst(rst), .setup_valid(sv_b), .setup_ready(sr_b),
      .FX1(fx[0]), .FX2(fx[1]), .FX3(fx[2]), .FX4(fx[3]),
      .FY1(fy[0]), .FY2(fy[1]), .FY3(fy[2]), .FY4(fy[3]),
      .FDX12(fdx[0]), .FDY12(fdy[0]), .FDX23(fdx[1]), .FDY23(fdy[1]),
      .FDX31(fdx[2]), .FDY31(fdy[2]), .FDX41(fdx[3]), .FDY41(fdy[3]),
      .quad(quad), .tile_x0(tx), .tile_y0(ty),
      .out_valid(ov_b), .out_ready(1'b1), .out_mask(om_b), .out_x(ox_b), .out_y(oy_b),
      .out_first(of_b), .out_last(ol_b), .out_any(any_b), .out_row_last(rl_b),
      .out_tile_last(tl_b), .busy(busy_b), .done(done_b)
   );
   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask
   // direct per-pixel edge evaluation, independent of the incremental scan
   function automatic logic [31:0] model_mask(input int px, input int py);
      logic [31:0] m = '0;
      logic signed [63:0] c, e;
      bit in;
      for (int k = 0; k < 32; k++) begin
         in = 1;
         for (int ed = 0; ed < 4; ed++) begin
            c = ((64'(fdy[ed]) * 64'(fx[ed])) >>> 4) - ((64'(fdx[ed]) * 64'(fy[ed])) >>> 4);
            e = c + 64'(fdx[ed]) * 64'(py) - 64'(fdy[ed]) * 64'(px + k);
            if (ed < 3 || quad) in = in && (e >= 0);
         end
         m[k] = in;
      end
      return m;
   endfunction
   task automatic push_tile(input logic [10:0] x0, input logic [10:0] y0);
      logic [31:0] m;
      logic [4:0] f, l;
      for (int r = 0; r < 32; r++) begin
         m = model_mask(int'(x0), int'(y0) + r);
         f = 0;
         l = 0;
         for (int k = 31; k >= 0; k--) if (m[k]) f = 5'(k);
         for (int k = 0; k < 32; k++) if (m[k]) l = 5'(k);
         q.push_back('{x: x0, y: 11'(y0 + 11'(r)), mask: m, first: f, last: l, any: |m, rl: 1'b1, tl: r == 31});
      end
   endtask
   task automatic wait_idle(input int lim);
      int n = 0;
      while ((q.size() != 0 || busy_a) && n < lim) begin
         @(negedge clk);
         n++;
      end
      if (n >= lim) begin
         n_chk++;
         n_err++;
         $display("FAIL wait_idle: timeout with %0d chunks outstanding", q.size());
         q.delete();
      end
      @(negedge clk);
   endtask
   task automatic run_vec(input vec_t v);
      quad = v.quad_v;
      tx = v.tx;
      ty = v.ty;
      cur_ty = v.ty;
      bp = v.bp;
      acc_cnt = 0;
      for (int r = 0; r < 32; r++) got_row[r] = 32'hDEADBEEF;
      push_tile(v.tx, v.ty);
      sv_a = 1;
      @(posedge clk);
      @(negedge clk) chk("latency_setup", {ov_a, busy_a, sr_a}, 3'b010);
      @(negedge clk) chk("latency_first", ov_a, 1'b1);
      sv_a = 0;
      wait_idle(400);
      chk("chunk_count", acc_cnt, 32);
      chk("row0_mask", got_row[0], v.row0);
      chk("row31_mask", got_row[31], v.row31);
   endtask
   task automatic run_b(input bit skip_case);
      int n = 0, cnt = 0;
      sv_b = 1;
      @(posedge clk);
      #1 sv_b = 0;
      do begin
         @(negedge clk);
         n++;
         if (ov_b) begin
            cnt++;
            if (!skip_case && cnt == 1) chk("b_first_chunk", {om_b, of_b, ol_b}, {8'hFF, 3'd0, 3'd7});
            if (!skip_case && cnt <= 4) chk("b_out_x", {ox_b, rl_b}, {11'(8 * (cnt - 1)), cnt == 4});
            if (skip_case && cnt <= 4) chk("b_skip_chunk", {ox_b, oy_b, om_b, tl_b}, {11'd0, 11'(cnt - 1), 8'hFF, 1'b0});
            if (skip_case && cnt > 4) chk("b_skip_final", {ox_b, oy_b, om_b, tl_b, any_b, of_b, ol_b}, {11'd24, 11'd31, 8'h00, 1'b1, 1'b0, 6'd0});
         end
      end while (busy_b && n < 400);
      chk("b_done", {busy_b, done_b}, 2'b01);
      chk(skip_case ? "b_skip_count" : "b_chunk_count", cnt, skip_case ? 5 : 128);
   endtask
   assign cur = {ox_a, oy_a, om_a, of_a, ol_a, any_a, rl_a, tl_a};
   always @(negedge clk) begin
      if (rst) begin
         exp_done = 0;
         stalled = 0;
      end else begin
         if (done_a || exp_done) chk("done_pulse", done_a, exp_done);
         exp_done = 0;
         if (stalled) chk("stall_hold", {ov_a, cur}, {1'b1, held});
         stalled = ov_a && !or_a;
         held = cur;
         if (ov_a && or_a) begin
            acc_cnt++;
            if (q.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL unexpected_chunk: got %0h, expected no chunk", cur);
            end else begin
               expc = q.pop_front();
               chk("chunk", cur, expc);
               got_row[5'(oy_a - cur_ty)] = om_a;
               exp_done = expc.tl;
            end
         end
      end
   end
   initial begin
      or_a = 1;
      forever begin
         @(posedge clk);
         #1 ph++;
         or_a = !bp || ph[1:0] == 2'd0 || ph[1:0] == 2'd3;
      end
   end
   initial begin
      int n;
      rst = 1;
      sv_a = 0;
      sv_b = 0;
      fdx = '{512, -512, 0, 0};
      fdy = '{0, 512, -512, 512};
      fx = '{0, 512, 0, 240};
      fy = '{0, 0, 512, 0};
      quad = 0;
      tx = 0;
      ty = 0;
      cur_ty = 0;
      vecs[0] = '{quad_v: 0, tx: 0, ty: 0, bp: 0, row0: 32'hFFFFFFFF, row31: 32'h3};
      vecs[1] = '{quad_v: 1, tx: 0, ty: 0, bp: 0, row0: 32'h0000FFFF, row31: 32'h3};
      vecs[2] = '{quad_v: 0, tx: 0, ty: 0, bp: 1, row0: 32'hFFFFFFFF, row31: 32'h3};
      vecs[3] = '{quad_v: 0, tx: 0, ty: 16, bp: 0, row0: 32'h0001FFFF, row31: 32'h0};
      vecs[4] = '{quad_v: 1, tx: 64, ty: 0, bp: 1, row0: 32'h0, row31: 32'h0};
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_a", {ov_a, sr_a, busy_a, done_a, om_a, ox_a, oy_a, of_a, ol_a, any_a, rl_a, tl_a}, {1'b0, 1'b1, 69'b0});
      chk("reset_b", {ov_b, sr_b, busy_b, done_b, om_b, ox_b, oy_b, of_b, ol_b, any_b, rl_b, tl_b}, {1'b0, 1'b1, 41'b0});
      @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      for (int i = 0; i < 5; i++) run_vec(vecs[i]);
      // abort a scan after ten chunks, then restart cleanly
      quad = 0;
      tx = 0;
      ty = 0;
      cur_ty = 0;
      bp = 0;
      push_tile(0, 0);
      sv_a = 1;
      @(posedge clk);
      #1 sv_a = 0;
      acc_cnt = 0;
      n = 0;
      while (acc_cnt < 10 && n < 100) begin
         @(posedge clk);
         n++;
      end
      chk("reached_chunk10", acc_cnt, 10);
      #1 rst = 1;
      q.delete();
      @(posedge clk);
      #1 rst = 0;
      @(negedge clk) chk("reset_mid_scan", {ov_a, busy_a, sr_a}, 3'b001);
      repeat (4) @(negedge clk) chk("no_done_after_reset", done_a, 1'b0);
      run_vec(vecs[0]);
      fdx = '{0, 0, 0, 0};
      fdy = '{0, 0, 0, 0};
      fx = '{0, 0, 0, 0};
      fy = '{0, 0, 0, 0};
      quad = 0;
      tx = 0;
      ty = 0;
      run_b(0);
      fdx = '{-1, 0, 0, 0};
      fdy = '{0, 1, 0, 0};
      fx = '{0, 112, 0, 0};
      fy = '{48, 0, 0, 0};
      run_b(1);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
